// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding, frame layout offsets and default sync marker for the UART memory loader
package loader_pkg;
    typedef enum logic [2:0] {
        WAIT_SYNC,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE
    } loader_state_t;
    localparam int unsigned OFF_SYNC   = 0;
    localparam int unsigned OFF_LEN_LO = 1;
    localparam int unsigned OFF_LEN_HI = 2;
    localparam int unsigned OFF_DATA   = 3;
    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;
endpackage

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: boot loader turning a UART frame (SYNC, LEN_LO, LEN_HI, 4*LEN data, XOR CSUM) into RAM word writes
//   clk, reset (async, active-high) | rx_data/rx_valid: received byte strobe
//   mem_addr/mem_wdata/mem_wmask/mem_rstrb: RAM write port | cpu_reset: held until DONE
//   busy: inside a frame | error: sticky checksum/overlength/timeout flag
module uart_mem_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR        = 32'h0000_0000,
    parameter int unsigned MEM_WORDS        = 3072,
    parameter logic [7:0]  SYNC_BYTE        = DEFAULT_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYCLES   = 1_200_000,
    parameter int unsigned BOOT_WAIT_CYCLES = 12_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic        mem_rstrb,
    output logic        cpu_reset,
    output logic        busy,
    output logic        error
);
    localparam int unsigned MAXC = (TIMEOUT_CYCLES > BOOT_WAIT_CYCLES) ? TIMEOUT_CYCLES : BOOT_WAIT_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    loader_state_t state, state_n;
    logic [15:0] len, len_n, len_full, word_idx, word_idx_n;
    logic [1:0]  byte_cnt, byte_cnt_n;
    logic [7:0]  csum, csum_n;
    logic [31:0] word, word_n, addr_n, wdata_n;
    logic [CW-1:0] cnt, cnt_n;
    logic wr, wr_n, armed, armed_n, err_n, in_frame, timeout, boot_hit, over;
    assign mem_wmask = wr ? 4'hF : 4'h0;
    assign mem_rstrb = 1'b0;
    assign cpu_reset = state != DONE;
    assign busy      = state != WAIT_SYNC && state != DONE;
    assign in_frame  = busy;
    assign len_full  = {rx_data, len[7:0]};
    assign over      = {16'b0, len_full} > MEM_WORDS;
    assign timeout   = in_frame && !rx_valid && cnt == CW'(TIMEOUT_CYCLES - 1);
    // The shared counter doubles as the boot-wait timer only until the first SYNC.
    assign boot_hit  = state == WAIT_SYNC && armed && BOOT_WAIT_CYCLES != 0 && cnt == CW'(BOOT_WAIT_CYCLES - 1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= WAIT_SYNC;
            len       <= '0;
            word_idx  <= '0;
            byte_cnt  <= '0;
            csum      <= '0;
            word      <= '0;
            cnt       <= '0;
            wr        <= 1'b0;
            armed     <= 1'b1;
            error     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_n;
            len       <= len_n;
            word_idx  <= word_idx_n;
            byte_cnt  <= byte_cnt_n;
            csum      <= csum_n;
            word      <= word_n;
            cnt       <= cnt_n;
            wr        <= wr_n;
            armed     <= armed_n;
            error     <= err_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
        end
    end
    always_comb begin
        state_n    = state;
        len_n      = len;
        word_idx_n = word_idx;
        byte_cnt_n = byte_cnt;
        csum_n     = csum;
        word_n     = word;
        wr_n       = 1'b0;
        armed_n    = armed;
        err_n      = error;
        addr_n     = mem_addr;
        wdata_n    = mem_wdata;
        cnt_n      = cnt;
        if (in_frame)
            cnt_n = rx_valid ? '0 : cnt + 1'b1;
        else if (state == WAIT_SYNC && armed && BOOT_WAIT_CYCLES != 0)
            cnt_n = cnt + 1'b1;
        if (timeout) begin
            state_n = WAIT_SYNC;
            err_n   = 1'b1;
            cnt_n   = '0;
        end else begin
            case (state)
                WAIT_SYNC: begin
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        state_n    = LEN_LO;
                        armed_n    = 1'b0;
                        word_idx_n = '0;
                        byte_cnt_n = '0;
                        csum_n     = '0;
                        cnt_n      = '0;
                    end else if (boot_hit) begin
                        state_n = DONE;
                    end
                end
                LEN_LO: begin
                    if (rx_valid) begin
                        len_n   = {8'h00, rx_data};
                        state_n = LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (rx_valid) begin
                        len_n   = len_full;
                        state_n = len_full == 16'd0 ? CSUM : over ? WAIT_SYNC : DATA;
                        err_n   = error | (len_full != 16'd0 && over);
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        word_n[{byte_cnt, 3'b000} +: 8] = rx_data;
                        csum_n     = csum ^ rx_data;
                        byte_cnt_n = byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            wr_n       = 1'b1;
                            addr_n     = BASE_ADDR + {14'b0, word_idx, 2'b00};
                            wdata_n    = {rx_data, word[23:0]};
                            word_idx_n = word_idx + 16'd1;
                            state_n    = word_idx_n == len ? CSUM : DATA;
                        end
                    end
                end
                CSUM: begin
                    if (rx_valid) begin
                        state_n = rx_data == csum ? DONE : WAIT_SYNC;
                        err_n   = error | (rx_data != csum);
                    end
                end
                DONE: ;
                default: state_n = WAIT_SYNC;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_mem_loader.sv
// tb_uart_mem_loader: randomized frames against a frame-level model; write scoreboard checked by a separate monitor
module tb_uart_mem_loader;
    localparam logic [31:0] BASE = 32'h0000_0000;
    logic clk = 1'b0, reset = 1'b1, rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0] mem_wmask;
    logic mem_rstrb, cpu_reset, busy, error;
    uart_mem_loader #(
        .BASE_ADDR(BASE), .MEM_WORDS(8), .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(50), .BOOT_WAIT_CYCLES(200)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rstrb(mem_rstrb), .cpu_reset(cpu_reset), .busy(busy), .error(error)
    );
    always #5 clk = ~clk;
    int cyc = 0, checks = 0, errors = 0, c0 = 0;
    always @(posedge clk) cyc <= cyc + 1;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          at;
    } wr_t;
    wr_t q[$];
    logic [31:0] fw[8];
    always @(negedge clk) begin
        if (!reset && mem_wmask != 4'h0) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h mask=%h, required no write", mem_addr, mem_wdata, mem_wmask);
            end else begin
                wr_t e;
                e = q.pop_front();
                if (mem_wmask !== 4'hF || mem_addr !== e.addr || mem_wdata !== e.data || cyc != e.at) begin
                    errors++;
                    $display("FAIL write: got addr=%h data=%h mask=%h cyc=%0d, required addr=%h data=%h mask=f cyc=%0d",
                             mem_addr, mem_wdata, mem_wmask, cyc, e.addr, e.data, e.at);
                end
            end
        end
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask
    function automatic int rg();
        return int'($urandom_range(0, 2));
    endfunction
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1 rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic send_frame(input int len, input logic [7:0] flip, input bit exp_wr);
        logic [7:0] x = 8'h00;
        logic [7:0] b;
        send_byte(8'hA5, rg());
        send_byte(len[7:0], rg());
        send_byte(len[15:8], rg());
        if (len <= 8) begin
            for (int i = 0; i < len; i++)
                for (int k = 0; k < 4; k++) begin
                    b = fw[i][8*k +: 8];
                    x ^= b;
                    if (k == 3 && exp_wr) q.push_back('{BASE + 32'(4 * i), fw[i], cyc + 1});
                    send_byte(b, rg());
                end
            send_byte(x ^ flip, rg());
        end
    endtask
    task automatic do_reset();
        chk("pending_writes", q.size(), 0);
        q.delete();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        c0 = cyc;
    endtask
    task automatic wait_edge(input int n);
        while (cyc < c0 + n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic check_idle(input string name);
        chk({name, "_addr"}, mem_addr, 0);
        chk({name, "_wdata"}, mem_wdata, 0);
        chk({name, "_wmask"}, mem_wmask, 0);
        chk({name, "_rstrb"}, mem_rstrb, 0);
        chk({name, "_cpu_reset"}, cpu_reset, 1);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_error"}, error, 0);
    endtask
    initial begin
        repeat (3) @(posedge clk);
        #1 check_idle("reset");
        reset = 1'b0;
        c0 = cyc;
        fw[0] = 32'h44332211;
        fw[1] = 32'h88776655;
        send_frame(2, 8'h00, 1'b1);
        chk("t1_cpu_reset", cpu_reset, 0);
        chk("t1_error", error, 0);
        chk("t1_busy", busy, 0);
        fw[0] = $urandom;
        fw[1] = $urandom;
        send_frame(2, 8'h00, 1'b0);
        chk("t1_done_ignores", cpu_reset, 0);
        do_reset();
        fw[0] = 32'h44332211;
        fw[1] = 32'h88776655;
        send_frame(2, 8'h01, 1'b1);
        repeat (2) @(posedge clk);
        #1 chk("t2_cpu_reset", cpu_reset, 1);
        chk("t2_error", error, 1);
        chk("t2_busy", busy, 0);
        send_frame(2, 8'h00, 1'b1);
        chk("t2_retry_cpu_reset", cpu_reset, 0);
        chk("t2_retry_error", error, 1);
        do_reset();
        send_frame(9, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1 chk("t3_error", error, 1);
        chk("t3_busy", busy, 0);
        chk("t3_cpu_reset", cpu_reset, 1);
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        repeat (60) @(posedge clk);
        #1 chk("t4_error", error, 1);
        chk("t4_busy", busy, 0);
        fw[0] = $urandom;
        send_frame(1, 8'h00, 1'b1);
        chk("t4_reload_cpu_reset", cpu_reset, 0);
        do_reset();
        wait_edge(199);
        chk("t5_cpu_reset_199", cpu_reset, 1);
        wait_edge(200);
        chk("t5_cpu_reset_200", cpu_reset, 0);
        chk("t5_error", error, 0);
        do_reset();
        wait_edge(9);
        send_byte(8'h00, 0);
        wait_edge(199);
        chk("t5b_cpu_reset_199", cpu_reset, 1);
        wait_edge(200);
        chk("t5b_cpu_reset_200", cpu_reset, 0);
        do_reset();
        wait_edge(9);
        send_byte(8'hA5, 0);
        wait_edge(300);
        chk("t5c_cpu_reset_300", cpu_reset, 1);
        chk("t5c_busy", busy, 0);
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        rx_valid = 1'b1;
        rx_data  = 8'h44;
        reset    = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
        check_idle("t6");
        reset = 1'b0;
        c0 = cyc;
        fw[0] = $urandom;
        fw[1] = $urandom;
        send_frame(2, 8'h00, 1'b1);
        chk("t6_reload_cpu_reset", cpu_reset, 0);
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        send_byte(8'hCC, 0);
        send_byte(8'hDD, 0);
        chk("t6_inflight_pulse", mem_wmask, 4'hF);
        reset = 1'b1;
        #1 chk("t6_async_drop", mem_wmask, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        c0 = cyc;
        for (int r = 0; r < 6; r++) begin
            int len;
            logic [7:0] flip;
            bit ok;
            do_reset();
            len  = int'($urandom_range(1, 8));
            flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            ok   = flip == 8'h00;
            for (int i = 0; i < 8; i++) fw[i] = $urandom;
            send_frame(len, flip, 1'b1);
            repeat (2) @(posedge clk);
            #1 chk("rand_cpu_reset", cpu_reset, {31'b0, !ok});
            chk("rand_error", error, {31'b0, !ok});
            chk("rand_busy", busy, 0);
        end
        chk("final_pending_writes", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
